// File: rtl/buffer_reader.sv
// buffer_reader
//   Read side of the byte-wide buffer. A start pulse supplies a base byte
//   address and a word count. The block then streams that many big-endian
//   32-bit words over a valid/ready handshake and pulses done once.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   mem       byte array from the buffer, [7:0] mem [0:SIZE-1]
//   start     one-cycle request, honoured only while idle
//   rd_adr    base byte address (reduced mod SIZE when captured)
//   rd_cnt    number of words to emit (0 gives an immediate done)
//   rd_data   current word, mem[a] in bits [31:24]
//   rd_valid  rd_data holds a word not yet accepted
//   rd_ready  consumer accepts rd_data when rd_valid & rd_ready
//   busy      high whenever a request is in progress (including done cycle)
//   done      one-cycle pulse after the last word is accepted
module buffer_reader #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem [0:SIZE-1],
  input  logic        start,
  input  logic [7:0]  rd_adr,
  input  logic [7:0]  rd_cnt,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] adr;
  logic [7:0]    cnt;

  // Byte addresses live in 0..SIZE-1; every offset folds back into that range.
  function automatic logic [AW-1:0] wrap(input logic [8:0] v);
    logic [8:0] r;
    r = v % 9'(SIZE);
    return r[AW-1:0];
  endfunction

  // Inverse of the write-side packing: lowest address is the most significant byte.
  function automatic logic [31:0] word_at(input logic [AW-1:0] a);
    return {mem[a],
            mem[wrap(9'(a) + 9'd1)],
            mem[wrap(9'(a) + 9'd2)],
            mem[wrap(9'(a) + 9'd3)]};
  endfunction

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      adr      <= '0;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            adr   <= wrap({1'b0, rd_adr});
            cnt   <= rd_cnt;
            state <= (rd_cnt == 8'd0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          rd_data  <= word_at(adr);
          rd_valid <= 1'b1;
          adr      <= wrap(9'(adr) + 9'd4);
          state    <= VALID;
        end
        VALID: begin
          // rd_data only moves on a handshake, so mem changes while stalled are invisible.
          if (rd_ready) begin
            if (cnt > 8'd1) begin
              rd_data <= word_at(adr);
              adr     <= wrap(9'(adr) + 9'd4);
              cnt     <= cnt - 8'd1;
            end else begin
              rd_valid <= 1'b0;
              cnt      <= 8'd0;
              state    <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader
//   Randomised and directed stimulus for buffer_reader, checked every cycle
//   against a transaction-level reference model, plus literal expectations
//   for the hand-worked cases.
module tb_buffer_reader;

  localparam int SIZE = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem [0:SIZE-1];
  logic        start;
  logic [7:0]  rd_adr;
  logic [7:0]  rd_cnt;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [31:0] acc [$];

  buffer_reader #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .mem(mem), .start(start), .rd_adr(rd_adr),
    .rd_cnt(rd_cnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(input int a);
    return {mem[a % SIZE], mem[(a + 1) % SIZE], mem[(a + 2) % SIZE], mem[(a + 3) % SIZE]};
  endfunction

  // Reference model: one outstanding request, described by words left, next
  // address, and whether the first fetch, a word, or the done pulse is pending.
  int          m_left, m_next;
  logic        m_busy, m_valid, m_done, m_loading;
  logic [31:0] m_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_valid = 0; m_done = 0; m_loading = 0; m_left = 0; m_next = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1;
        m_next = rd_adr % SIZE;
        m_left = rd_cnt;
        if (rd_cnt == 0) m_done = 1;
        else m_loading = 1;
      end
    end else if (m_loading) begin
      m_loading = 0;
      m_data    = mword(m_next);
      m_next    = (m_next + 4) % SIZE;
      m_valid   = 1;
    end else if (m_valid && rd_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_valid = 0; m_done = 1;
      end else begin
        m_data = mword(m_next);
        m_next = (m_next + 4) % SIZE;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("busy", busy, m_busy);
    check("rd_valid", rd_valid, m_valid);
    check("done", done, m_done);
    if (m_valid) check("rd_data", rd_data, m_data);
    if (done) done_cnt++;
  end

  // Words actually handed over to the consumer.
  always @(posedge clk) begin
    if (!rst && rd_valid && rd_ready) acc.push_back(rd_data);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input int a, input int n);
    step();
    start = 1'b1; rd_adr = 8'(a); rd_cnt = 8'(n);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s timeout actual=no_done required=done", name);
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; rd_adr = '0; rd_cnt = '0; rd_ready = 1'b0;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'(i);
    step(); step();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    // Two back-to-back words from address 0.
    acc.delete(); base = done_cnt; rd_ready = 1'b1;
    do_start(0, 2);
    wait_done("t1", 20);
    check("t1_words", acc.size(), 2);
    if (acc.size() == 2) begin
      check("t1_w0", acc[0], 32'h00010203);
      check("t1_w1", acc[1], 32'h04050607);
    end
    check("t1_done", done_cnt - base, 1);

    // Wrap past the end of the array.
    acc.delete(); base = done_cnt;
    do_start(62, 1);
    wait_done("t2", 20);
    check("t2_words", acc.size(), 1);
    if (acc.size() == 1) check("t2_w0", acc[0], 32'h3E3F0001);
    check("t2_done", done_cnt - base, 1);

    // Stall on word 2; a mem change during the stall must not leak through.
    acc.delete(); base = done_cnt; rd_ready = 1'b0;
    do_start(0, 3);
    for (int k = 0; k < 10 && !rd_valid; k++) step();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    mem[5] = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_hold", rd_data, 32'h04050607);
      check("t3_hold_vld", rd_valid, 1'b1);
    end
    mem[5] = 8'h05;
    rd_ready = 1'b1;
    wait_done("t3", 20);
    check("t3_words", acc.size(), 3);
    if (acc.size() == 3) check("t3_w2", acc[2], 32'h08090A0B);
    check("t3_done", done_cnt - base, 1);

    // Zero-length request.
    acc.delete(); base = done_cnt;
    do_start(5, 0);
    check("t4_done_now", done, 1'b1);
    check("t4_busy_now", busy, 1'b1);
    step();
    check("t4_busy_after", busy, 1'b0);
    check("t4_words", acc.size(), 0);
    check("t4_done", done_cnt - base, 1);

    // Restart attempt while busy, then reset during word 2 of 4.
    acc.delete(); base = done_cnt;
    do_start(16, 4);
    start = 1'b1; rd_adr = 8'd0; rd_cnt = 8'd9;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("t5_rst_vld", rd_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("t5_words", acc.size(), 1);
    if (acc.size() == 1) check("t5_w0", acc[0], 32'h10111213);
    check("t5_no_done", done_cnt - base, 0);
    acc.delete(); base = done_cnt;
    do_start(4, 2);
    wait_done("t5b", 20);
    check("t5b_words", acc.size(), 2);
    if (acc.size() == 2) check("t5b_w1", acc[1], 32'h08090A0B);
    check("t5b_done", done_cnt - base, 1);

    // Same-edge write on the LOAD edge returns old bytes.
    acc.delete();
    do_start(8, 1);
    @(posedge clk);
    mem[8] <= 8'hDE; mem[9] <= 8'hAD; mem[10] <= 8'hBE; mem[11] <= 8'hEF;
    wait_done("t6", 20);
    if (acc.size() == 1) check("t6_old", acc[0], 32'h08090A0B);
    else check("t6_words", acc.size(), 1);
    acc.delete();
    do_start(8, 1);
    wait_done("t6b", 20);
    if (acc.size() == 1) check("t6_new", acc[0], 32'hDEADBEEF);
    else check("t6b_words", acc.size(), 1);

    // Random transactions with random backpressure and spurious starts.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
      acc.delete(); base = done_cnt;
      rd_ready = 1'($urandom);
      begin
        int n;
        n = $urandom_range(0, 6);
        do_start($urandom_range(0, 255), n);
        for (int k = 0; k < 200 && !done; k++) begin
          rd_ready = ($urandom_range(0, 3) != 0);
          start = (busy && !done && $urandom_range(0, 7) == 0);
          rd_adr = 8'($urandom);
          rd_cnt = 8'($urandom);
          step();
        end
        start = 1'b0;
        wait_done("rand", 5);
        check("rand_words", acc.size(), n);
        check("rand_done", done_cnt - base, 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
